// File: rtl/pistorm_pkg.sv
// ============================================================================
//  Module      : pistorm_pkg
//  Description : Shared arbitration state encoding and status-bit positions.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package pistorm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HOLD    = 3'd1,
        ST_GRANT   = 3'd2,
        ST_OWNED   = 3'd3,
        ST_RELEASE = 3'd4
    } arb_state_t;

    // Bit positions of the arbitration flags inside the Pi status register
    localparam int c_STAT_DMA_ACTIVE_BIT = 0;
    localparam int c_STAT_GRANT_ERR_BIT  = 1;

endpackage

`default_nettype wire

// File: rtl/sync3.sv
// ============================================================================
//  Module      : sync3
//  Description : Three-flop synchroniser exposing every tap of the chain.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module sync3 #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_d,
    output logic [2:0] o_taps
);

    logic [2:0] r_chain;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_chain <= {3{RESET_VAL}};
        end else begin
            r_chain <= {r_chain[1:0], i_d};
        end
    end

    assign o_taps = r_chain;

endmodule

`default_nettype wire

// File: rtl/m68k_bus_arbiter.sv
// ============================================================================
//  Module      : m68k_bus_arbiter
//  Description : BR_n/BG_n/BGACK_n arbiter between the Pi engine and DMA masters.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module m68k_bus_arbiter
    import pistorm_pkg::*;
#(
    parameter int GRANT_TIMEOUT  = 16,
    parameter int RELEASE_SETTLE = 2
) (
    input  logic PI_CLK,
    input  logic RESET_n,
    input  logic M68K_CLK,
    input  logic M68K_BR_n,
    input  logic M68K_BGACK_n,
    input  logic bus_busy,
    input  logic clr_err,
    output logic M68K_BG_n,
    output logic bus_hold,
    output logic bus_float,
    output logic dma_active,
    output logic grant_timeout_err
);

    localparam logic [4:0] c_TO_LAST     = 5'(GRANT_TIMEOUT - 1);
    localparam logic [1:0] c_SETTLE_LAST = 2'(RELEASE_SETTLE - 1);

    logic [2:0] w_c7m_taps;
    logic [2:0] w_br_taps;
    logic [2:0] w_bgack_taps;
    logic       w_c7m_fall;
    logic       w_br;
    logic       w_bgack;
    logic       w_timeout;
    logic       w_unused_taps;
    arb_state_t w_next;

    arb_state_t r_state;
    logic [4:0] r_tcnt;
    logic [1:0] r_scnt;
    logic       r_armed;

    sync3 #(.RESET_VAL(1'b0)) u_sync_c7m (
        .clk    (PI_CLK),
        .rst_n  (RESET_n),
        .i_d    (M68K_CLK),
        .o_taps (w_c7m_taps)
    );

    sync3 #(.RESET_VAL(1'b1)) u_sync_br (
        .clk    (PI_CLK),
        .rst_n  (RESET_n),
        .i_d    (M68K_BR_n),
        .o_taps (w_br_taps)
    );

    sync3 #(.RESET_VAL(1'b1)) u_sync_bgack (
        .clk    (PI_CLK),
        .rst_n  (RESET_n),
        .i_d    (M68K_BGACK_n),
        .o_taps (w_bgack_taps)
    );

    assign w_c7m_fall    = w_c7m_taps[2] & ~w_c7m_taps[1];
    assign w_br          = ~w_br_taps[2];
    assign w_bgack       = ~w_bgack_taps[2];
    assign w_unused_taps = ^{w_c7m_taps[0], w_br_taps[1:0], w_bgack_taps[1:0]};

    always_comb begin
        w_next    = r_state;
        w_timeout = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_br) w_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (!w_br)
                    w_next = ST_IDLE;
                else if (w_c7m_fall && r_armed && !bus_busy)
                    w_next = ST_GRANT;
            end
            ST_GRANT: begin
                if (w_bgack) begin
                    w_next = ST_OWNED;
                end else if (!w_br) begin
                    w_next = ST_IDLE;
                end else if (w_c7m_fall && r_tcnt == c_TO_LAST) begin
                    w_next    = ST_IDLE;
                    w_timeout = 1'b1;
                end
            end
            ST_OWNED: begin
                if (!w_bgack) w_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // A request already waiting goes straight back to HOLD so no Pi cycle slips in
                if (w_c7m_fall && r_scnt == c_SETTLE_LAST)
                    w_next = w_br ? ST_HOLD : ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge PI_CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            r_state           <= ST_IDLE;
            r_tcnt            <= 5'd0;
            r_scnt            <= 2'd0;
            r_armed           <= 1'b0;
            M68K_BG_n         <= 1'b1;
            bus_hold          <= 1'b0;
            bus_float         <= 1'b0;
            dma_active        <= 1'b0;
            grant_timeout_err <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_next != r_state) begin
                r_tcnt <= 5'd0;
                r_scnt <= 2'd0;
            end else if (w_c7m_fall) begin
                if (r_state == ST_GRANT && r_tcnt != 5'h1F)
                    r_tcnt <= r_tcnt + 5'd1;
                if (r_state == ST_RELEASE && r_scnt != 2'h3)
                    r_scnt <= r_scnt + 2'd1;
            end

            // One c7m_fall seen inside HOLD guarantees a full bus period before the granting fall
            if (r_state != ST_HOLD)
                r_armed <= (r_state == ST_RELEASE);
            else if (w_c7m_fall)
                r_armed <= 1'b1;

            M68K_BG_n  <= (w_next != ST_GRANT);
            bus_hold   <= (w_next != ST_IDLE);
            bus_float  <= (w_next == ST_OWNED) || (w_next == ST_RELEASE);
            dma_active <= (w_next == ST_OWNED);

            if (w_timeout)
                grant_timeout_err <= 1'b1;
            else if (clr_err)
                grant_timeout_err <= 1'b0;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_m68k_bus_arbiter.sv
// ============================================================================
//  Module      : tb_m68k_bus_arbiter
//  Description : Directed self-checking bench for m68k_bus_arbiter.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_m68k_bus_arbiter;

    localparam int B_BG    = 4;
    localparam int B_HOLD  = 3;
    localparam int B_FLOAT = 2;
    localparam int B_DMA   = 1;
    localparam int B_ERR   = 0;
    localparam int M_PER   = 28;

    logic PI_CLK       = 1'b0;
    logic RESET_n      = 1'b0;
    logic M68K_CLK     = 1'b0;
    logic M68K_BR_n    = 1'b1;
    logic M68K_BGACK_n = 1'b1;
    logic bus_busy     = 1'b0;
    logic clr_err      = 1'b0;
    logic M68K_BG_n;
    logic bus_hold;
    logic bus_float;
    logic dma_active;
    logic grant_timeout_err;
    logic [4:0] w_outs;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string tag;
        int    val;
    } exp_t;

    exp_t sb_q[$];

    m68k_bus_arbiter #(
        .GRANT_TIMEOUT  (16),
        .RELEASE_SETTLE (2)
    ) dut (
        .PI_CLK            (PI_CLK),
        .RESET_n           (RESET_n),
        .M68K_CLK          (M68K_CLK),
        .M68K_BR_n         (M68K_BR_n),
        .M68K_BGACK_n      (M68K_BGACK_n),
        .bus_busy          (bus_busy),
        .clr_err           (clr_err),
        .M68K_BG_n         (M68K_BG_n),
        .bus_hold          (bus_hold),
        .bus_float         (bus_float),
        .dma_active        (dma_active),
        .grant_timeout_err (grant_timeout_err)
    );

    assign w_outs = {M68K_BG_n, bus_hold, bus_float, dma_active, grant_timeout_err};

    always #5 PI_CLK = ~PI_CLK;
    always #140 M68K_CLK = ~M68K_CLK;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge PI_CLK);
            #1;
        end
    endtask

    task automatic expect_val(input string tag, input int val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input int obs);
        exp_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wait_out(input int idx, input logic val, input int bound, output int n);
        n = 0;
        while (w_outs[idx] !== val && n < bound) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        int  n2;
        logic ok;

        tick(3);
        RESET_n = 1'b1;
        tick(2);
        expect_val("reset_outs", 5'b10000);
        check(int'(w_outs));

        // Pi cycle in flight when the external request arrives
        bus_busy  = 1'b1;
        M68K_BR_n = 1'b0;
        expect_val("br_to_hold_cycles", 1);
        wait_out(B_HOLD, 1'b1, 10, n);
        check(int'(n >= 3 && n <= 4));
        ok = 1'b1;
        repeat (3 * M_PER) begin
            tick();
            if (M68K_BG_n !== 1'b1 || bus_hold !== 1'b1) ok = 1'b0;
        end
        expect_val("bg_held_while_busy", 1);
        check(int'(ok));
        bus_busy = 1'b0;
        expect_val("busy_drop_to_bg_cycles", 1);
        wait_out(B_BG, 1'b0, 64, n);
        check(int'(n >= 1 && n <= M_PER + 4));
        expect_val("grant_outs", 5'b01000);
        check(int'(w_outs));

        // Full handshake
        tick(2 * M_PER);
        M68K_BGACK_n = 1'b0;
        expect_val("bgack_to_bg_high_cycles", 1);
        wait_out(B_BG, 1'b1, 10, n);
        check(int'(n >= 3 && n <= 4));
        expect_val("owned_outs", 5'b11110);
        check(int'(w_outs));
        M68K_BR_n = 1'b1;
        ok = 1'b1;
        repeat (10 * M_PER) begin
            tick();
            if (bus_float !== 1'b1 || dma_active !== 1'b1 || bus_hold !== 1'b1) ok = 1'b0;
        end
        expect_val("owned_float_dma_steady", 1);
        check(int'(ok));
        M68K_BGACK_n = 1'b1;
        expect_val("bgack_neg_to_dma_low", 1);
        wait_out(B_DMA, 1'b0, 10, n);
        check(int'(n >= 3 && n <= 4));
        wait_out(B_HOLD, 1'b0, 100, n2);
        expect_val("bgack_neg_to_hold_low", 1);
        check(int'((n + n2) >= M_PER && (n + n2) <= 2 * M_PER + 6));
        expect_val("idle_after_release", 5'b10000);
        check(int'(w_outs));

        // Grant never acknowledged
        M68K_BR_n = 1'b0;
        expect_val("timeout_grant_wait", 1);
        wait_out(B_BG, 1'b0, 100, n);
        check(int'(n <= 2 * M_PER + 8));
        expect_val("grant_to_timeout_cycles", 1);
        wait_out(B_BG, 1'b1, 600, n);
        check(int'(n >= 16 * M_PER - 2 && n <= 16 * M_PER + 2));
        expect_val("timeout_err_set", 1);
        check(int'(grant_timeout_err));
        M68K_BR_n = 1'b1;
        tick(70);
        expect_val("err_sticky_idle", 5'b10001);
        check(int'(w_outs));
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        tick();
        expect_val("err_cleared", 5'b10000);
        check(int'(w_outs));

        // Short request withdrawn before any acknowledge
        M68K_BR_n = 1'b0;
        tick(M_PER);
        M68K_BR_n = 1'b1;
        tick(20);
        expect_val("br_pulse_idle", 5'b10000);
        check(int'(w_outs));

        // Second request arriving during RELEASE
        M68K_BR_n = 1'b0;
        expect_val("chain_first_grant", 1);
        wait_out(B_BG, 1'b0, 100, n);
        check(int'(n <= 2 * M_PER + 8));
        M68K_BGACK_n = 1'b0;
        wait_out(B_BG, 1'b1, 10, n);
        tick(M_PER);
        M68K_BR_n = 1'b1;
        tick(M_PER);
        M68K_BGACK_n = 1'b1;
        tick(8);
        M68K_BR_n = 1'b0;
        ok = 1'b1;
        n  = 0;
        while (M68K_BG_n !== 1'b0 && n < 150) begin
            tick();
            n++;
            if (bus_hold !== 1'b1) ok = 1'b0;
        end
        expect_val("chain_hold_never_drops", 1);
        check(int'(ok));
        expect_val("chain_second_grant", 1);
        check(int'(n < 150));
        expect_val("chain_grant_outs", 5'b01000);
        check(int'(w_outs));

        // Reset while an external master owns the bus
        M68K_BGACK_n = 1'b0;
        wait_out(B_BG, 1'b1, 10, n);
        expect_val("pre_reset_owned", 5'b11110);
        check(int'(w_outs));
        #2;
        RESET_n = 1'b0;
        #1;
        expect_val("async_reset_outs", 5'b10000);
        check(int'(w_outs));
        M68K_BGACK_n = 1'b1;
        M68K_BR_n    = 1'b1;
        tick(3);
        RESET_n = 1'b1;
        tick(3);
        M68K_BR_n = 1'b0;
        expect_val("post_reset_grant", 1);
        wait_out(B_BG, 1'b0, 100, n);
        check(int'(n <= 2 * M_PER + 8));
        M68K_BGACK_n = 1'b0;
        expect_val("post_reset_ack_cycles", 1);
        wait_out(B_BG, 1'b1, 10, n);
        check(int'(n >= 3 && n <= 4));
        expect_val("post_reset_owned", 5'b11110);
        check(int'(w_outs));
        M68K_BR_n    = 1'b1;
        M68K_BGACK_n = 1'b1;
        wait_out(B_HOLD, 1'b0, 100, n);
        expect_val("post_reset_idle", 5'b10000);
        check(int'(w_outs));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
